// File: rtl/register_flags_stack_pkg.sv
// Shared defaults, flag bit indices and the shadow-stack operation encoding
// for the register flags stack.
package register_flags_stack_pkg;

    localparam int FLAG_W_DEF = 2;
    localparam int DEPTH_DEF  = 4;

    localparam int FLAG_X = 0;
    localparam int FLAG_Y = 1;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        SWAP = 2'd3
    } stack_op_e;

endpackage

// File: rtl/register_flags_stack_bit.sv
// One flag bit: dual-rail mask / pop / full-write mux chain feeding a
// dual-rail flop whose rails reset to 0 / 1.
module register_flag_bit (
    input  logic clk,
    input  logic clk_n,
    input  logic rst,
    input  logic wr_data,
    input  logic wr_data_n,
    input  logic pf_we,
    input  logic pf_we_n,
    input  logic pop,
    input  logic pop_n,
    input  logic top,
    input  logic top_n,
    input  logic pr_write,
    input  logic pr_write_n,
    output logic q,
    output logic q_n
);

    logic m1, m1_n, m2, m2_n, d, d_n;

    // Each stage selects on its true rail; the complement rail selects on
    // the complement select so both rails stay mirror images.
    assign m1   = pf_we      ? wr_data   : q;
    assign m1_n = pf_we_n    ? q_n       : wr_data_n;
    assign m2   = pop        ? top       : m1;
    assign m2_n = pop_n      ? m1_n      : top_n;
    assign d    = pr_write   ? wr_data   : m2;
    assign d_n  = pr_write_n ? m2_n      : wr_data_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    always_ff @(negedge clk_n or posedge rst) begin
        if (rst) q_n <= 1'b1;
        else     q_n <= d_n;
    end

endmodule

// File: rtl/register_flags_stack.sv
// Processor flags register with a shadow stack for exception save/restore,
// plus sticky overflow / underflow indicators.
module register_flags_stack
    import register_flags_stack_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       Clk,
    input  logic                       notClk,
    input  logic                       Rst,
    input  logic [FLAG_W-1:0]          notALUFlags,
    input  logic [FLAG_W-1:0]          PF_Write,
    input  logic [FLAG_W-1:0]          notPF_Write,
    input  logic                       PR_Write,
    input  logic                       notPR_Write,
    input  logic                       PR_Save,
    input  logic                       notPR_Save,
    input  logic                       PR_Ex,
    input  logic                       notPR_Ex,
    output logic [FLAG_W-1:0]          F,
    output logic [FLAG_W-1:0]          notF,
    output logic [$clog2(DEPTH):0]     Level,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [FLAG_W-1:0] stack_mem [DEPTH];
    logic [LW-1:0]     level_q;
    logic [AW-1:0]     top_idx;
    logic [FLAG_W-1:0] top_entry;
    logic              save, ex, empty, full;
    logic              pop_sel, pop_sel_n;
    stack_op_e         op;

    assign save      = PR_Save & ~notPR_Save;
    assign ex        = PR_Ex & ~notPR_Ex;
    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign top_idx   = level_q[AW-1:0] - AW'(1);
    assign top_entry = stack_mem[top_idx];

    // Both a plain pop and a swap load the top entry into the flags.
    assign pop_sel   = PR_Ex & ~empty;
    assign pop_sel_n = notPR_Ex | empty;

    always_comb begin
        op = NONE;
        if (save && ex) op = empty ? PUSH : SWAP;
        else if (save)  op = PUSH;
        else if (ex)    op = POP;
    end

    // Entries at or above Level are never read, so storage needs no reset.
    always_ff @(posedge Clk) begin
        if (op == PUSH && !full)
            stack_mem[level_q[AW-1:0]] <= F;
        else if (op == SWAP)
            stack_mem[top_idx] <= F;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            level_q   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            case (op)
                PUSH: begin
                    if (full) Overflow <= 1'b1;
                    else      level_q  <= level_q + LW'(1);
                end
                POP: begin
                    if (empty) Underflow <= 1'b1;
                    else       level_q   <= level_q - LW'(1);
                end
                default: ;
            endcase
        end
    end

    assign Level = level_q;

    for (genvar i = 0; i < FLAG_W; i++) begin : g_flag
        register_flag_bit u_bit (
            .clk        (Clk),
            .clk_n      (notClk),
            .rst        (Rst),
            .wr_data    (~notALUFlags[i]),
            .wr_data_n  (notALUFlags[i]),
            .pf_we      (PF_Write[i]),
            .pf_we_n    (notPF_Write[i]),
            .pop        (pop_sel),
            .pop_n      (pop_sel_n),
            .top        (top_entry[i]),
            .top_n      (~top_entry[i]),
            .pr_write   (PR_Write),
            .pr_write_n (notPR_Write),
            .q          (F[i]),
            .q_n        (notF[i])
        );
    end

endmodule

// File: doc/register_flags_stack.md
REGISTER_FLAGS_STACK -- requirements
Module: register_flags_stack

Interface
REQ-001 SHALL have parameter FLAG_W, default 2: number of flag bits held (F_X, F_Y, ...).
REQ-002 SHALL have parameter DEPTH, default 4: shadow-stack entries, power of two, DEPTH >= 2.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port notClk, input, 1: complement rail of Clk, driven externally as ~Clk.
REQ-005 SHALL have port Rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port notALUFlags, input, FLAG_W: inverted ALU flag results; this is the write data.
REQ-007 SHALL have ports PF_Write / notPF_Write, input, FLAG_W each: per-flag write-enable mask and its complement.
REQ-008 SHALL have ports PR_Write / notPR_Write, input, 1 each: write all flags from notALUFlags.
REQ-009 SHALL have ports PR_Save / notPR_Save, input, 1 each: exception entry; push current flags onto the shadow stack.
REQ-010 SHALL have ports PR_Ex / notPR_Ex, input, 1 each: exception return; pop the shadow stack into the flags.
REQ-011 SHALL have ports F / notF, output, FLAG_W each: registered flags and their exact complement.
REQ-012 SHALL have port Level, output, clog2(DEPTH)+1: number of occupied stack entries.
REQ-013 SHALL have port Overflow, output, 1: sticky; set by a push when the stack is full.
REQ-014 SHALL have port Underflow, output, 1: sticky; set by a pop when the stack is empty.

Function
REQ-015 Flag next-state priority SHALL be PR_Write > valid pop > PF_Write mask > hold.
- PR_Write: all bits = ~notALUFlags.
- Valid pop: all bits = top entry.
- PF_Write: bit i = ~notALUFlags[i] where PF_Write[i]=1; other bits hold.
REQ-016 notF SHALL equal ~F in every cycle, including during reset.
REQ-017 A push (PR_Save=1 and Level<DEPTH) SHALL store the pre-edge F at index Level and increment Level, in one cycle.
REQ-018 A pop (PR_Ex=1 and Level>0) SHALL supply entry Level-1 and decrement Level, in one cycle.
REQ-019 PR_Save and PR_Ex together with Level>0 SHALL swap: F takes the top entry unless PR_Write overrides; the top entry takes the pre-edge F; Level is unchanged.
REQ-020 PR_Save and PR_Ex together with Level=0 SHALL be a push only; Underflow is not set.
REQ-021 A push with Level=DEPTH SHALL leave the stack and Level unchanged and SHALL set Overflow.
REQ-022 A pop with Level=0 SHALL leave Level unchanged and SHALL set Underflow; F follows the PR_Write / PF_Write rules.
REQ-023 PR_Write together with a valid pop SHALL still decrement Level; the popped value is discarded.
REQ-024 Overflow and Underflow SHALL clear only on reset.
REQ-025 Latency SHALL be one Clk edge from any control input to F, Level or the sticky flags; F SHALL have no combinational path from inputs.
REQ-026 Stack entries above Level SHALL be don't-care and SHALL NOT be observable.

Reset
REQ-027 While Rst=1, the block SHALL hold F=0, notF=all ones, Level=0, Overflow=0, Underflow=0, asynchronously.
REQ-028 Stack contents SHALL NOT require reset.
REQ-029 Reset asserted mid-operation SHALL discard any pending push or pop.
REQ-030 The first edge after Rst deasserts SHALL be treated as a normal cycle.

Structure
REQ-031 A shared package SHALL hold the FLAG_W/DEPTH defaults, the flag bit indices (FLAG_X=0, FLAG_Y=1) and the stack-operation enum: NONE, PUSH, POP, SWAP.
REQ-032 Per-flag storage SHALL be one sub-module, register_flag_bit: a three-level dual-rail mux chain feeding a dual-rail DFF with asynchronous reset, instantiated FLAG_W times.

Verification
REQ-033 Reset: Rst=1 mid-cycle -> F=00 and notF=11 immediately, Level=0, stickies=0.
REQ-034 Masked write: notALUFlags=00, PF_Write=01 from F=00 -> F=01; then PF_Write=10 -> F=11.
REQ-035 Nested save/restore: with F=01 push, set F=10, push, set F=11, then pop twice -> F=10 then F=01, Level 2 -> 1 -> 0.
REQ-036 Boundaries, DEPTH=4:
- 5 pushes -> Level=4, Overflow=1, entries 0-3 intact.
- Pop at Level=0 -> Underflow=1, F unchanged.
REQ-037 Simultaneous events:
- PR_Save+PR_Ex with F=11, top=00 -> F=00, top=11, Level unchanged.
- PR_Write+pop with notALUFlags=10 -> F=01, Level decrements.
REQ-038 Random stimulus against a reference model of the stack, 10k cycles -> notF==~F in every cycle and zero mismatches.
